// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- shared definitions for the hex-printing UART front end.
//
// Contents:
//   state_e        : FSM state encoding (IDLE, SEND, GAP)
//   ASCII_*        : character constants used by the digit mapper and the
//                    optional CR/LF terminator
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;

endpackage : uart_pkg

// File: rtl/hex_to_ascii.sv
// -----------------------------------------------------------------------------
// hex_to_ascii -- purely combinational nibble to ASCII hex digit mapper.
//
// Parameters:
//   UPPERCASE : 1 -> 'A'..'F', 0 -> 'a'..'f'
// Ports:
//   nibble_i [3:0] : value 0..15
//   ascii_o  [7:0] : '0'..'9' for 0..9, letter for 10..15
// -----------------------------------------------------------------------------
module hex_to_ascii
    import uart_pkg::*;
#(
    parameter int UPPERCASE = 1
) (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    localparam logic [7:0] LETTER_BASE = (UPPERCASE != 0) ? ASCII_UPPER_A : ASCII_LOWER_A;

    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = ASCII_ZERO + {4'b0000, nibble_i};
        end else begin
            ascii_o = LETTER_BASE + {4'b0000, nibble_i} - 8'd10;
        end
    end

endmodule : hex_to_ascii

// File: rtl/uart_hex_tx.sv
// -----------------------------------------------------------------------------
// uart_hex_tx -- prints a word as ASCII hex digits, one byte strobe at a time,
// into a byte-wide UART transmitter.
//
// Parameters:
//   NIBBLES    : hex digits per word (1..8), most-significant first
//   UPPERCASE  : 1 -> 'A'..'F', 0 -> 'a'..'f'
//   GAP_CYCLES : idle cycles after each strobe before tx_free is looked at (1..15)
// Build option:
//   UART_HEX_TX_CRLF_EN : when defined, every word is followed by 0x0D 0x0A
// Ports:
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   in_data[31:0] : word to print (low 4*NIBBLES bits used)
//   in_valid      : in_data offered
//   in_ready      : word accepted this cycle if in_valid (FSM idle)
//   tx_free       : transmitter can take a byte
//   tx_data[7:0]  : ASCII byte, stable from its strobe until the next strobe
//   tx_data_valid : single-cycle strobe qualifying tx_data
//   busy          : a word is being emitted
// -----------------------------------------------------------------------------
module uart_hex_tx
    import uart_pkg::*;
#(
    parameter int NIBBLES    = 8,
    parameter int UPPERCASE  = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        tx_free,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    output logic        busy
);

`ifdef UART_HEX_TX_CRLF_EN
    localparam int TOTAL_BYTES = NIBBLES + 2;
`else
    localparam int TOTAL_BYTES = NIBBLES;
`endif

    // The word is left-aligned on acceptance so the next digit is always
    // word_q[31:28], whatever NIBBLES is.
    localparam int ALIGN_SHIFT = 32 - 4 * NIBBLES;

    state_e      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  gap_q, gap_d;
    logic [7:0]  tx_hold_q, tx_hold_d;

    logic        accept;
    logic        strobe;
    logic [7:0]  digit_ascii;
    logic [7:0]  cur_byte;

    hex_to_ascii #(
        .UPPERCASE (UPPERCASE)
    ) u_hex_to_ascii (
        .nibble_i (word_q[31:28]),
        .ascii_o  (digit_ascii)
    );

    assign accept = in_valid && (state_q == IDLE);
    // Reset gates the strobe so a word abandoned by rst emits nothing more,
    // not even in the cycle rst is sampled.
    assign strobe = (state_q == SEND) && tx_free && !rst;

    // Byte selection: hex digits first, then the optional terminator.
    always_comb begin
`ifdef UART_HEX_TX_CRLF_EN
        if (idx_q == 4'(NIBBLES)) begin
            cur_byte = ASCII_CR;
        end else if (idx_q > 4'(NIBBLES)) begin
            cur_byte = ASCII_LF;
        end else begin
            cur_byte = digit_ascii;
        end
`else
        cur_byte = digit_ascii;
`endif
    end

    // ---------------------------------------------------------------- state reg
    // NOTE: reset is synchronous, so it lives inside the clocked branch and the
    // sensitivity list holds only the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = SEND;
            SEND: if (tx_free)  state_d = GAP;
            GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = (idx_q == 4'(TOTAL_BYTES)) ? IDLE : SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        in_ready      = (state_q == IDLE);
        busy          = (state_q != IDLE);
        tx_data_valid = strobe;
        // The new byte must be visible in its own strobe cycle; afterwards
        // the registered copy keeps it stable until the next strobe.
        tx_data       = strobe ? cur_byte : tx_hold_q;
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        word_d    = word_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        tx_hold_d = tx_hold_q;
        if (accept) begin
            word_d = in_data << ALIGN_SHIFT;
            idx_d  = 4'd0;
        end
        if (strobe) begin
            word_d    = word_q << 4;
            idx_d     = idx_q + 4'd1;
            gap_d     = 4'(GAP_CYCLES - 1);
            tx_hold_d = cur_byte;
        end
        if ((state_q == GAP) && (gap_q != 4'd0)) begin
            gap_d = gap_q - 4'd1;
        end
    end

    // NOTE: state registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q    <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            tx_hold_q <= '0;
        end else begin
            word_q    <= word_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            tx_hold_q <= tx_hold_d;
        end
    end

endmodule : uart_hex_tx

// File: tb/tb_uart_hex_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_hex_tx -- directed bench for uart_hex_tx.
//   dut0 : default parameters (8 digits, uppercase, gap 2)
//   dut1 : NIBBLES=4, UPPERCASE=0
// Expected byte streams are hand-written strings; CR/LF are appended when the
// bundle is built with UART_HEX_TX_CRLF_EN.
// -----------------------------------------------------------------------------
module tb_uart_hex_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dut0 signals
    logic        rst0 = 1'b1;
    logic [31:0] in_data0 = '0;
    logic        in_valid0 = 1'b0;
    logic        in_ready0;
    logic        tx_free0 = 1'b1;
    logic [7:0]  tx_data0;
    logic        tx_vld0;
    logic        busy0;

    // dut1 signals
    logic        rst1 = 1'b1;
    logic [31:0] in_data1 = '0;
    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [7:0]  tx_data1;
    logic        tx_vld1;
    logic        busy1;

    uart_hex_tx dut0 (
        .clk           (clk),
        .rst           (rst0),
        .in_data       (in_data0),
        .in_valid      (in_valid0),
        .in_ready      (in_ready0),
        .tx_free       (tx_free0),
        .tx_data       (tx_data0),
        .tx_data_valid (tx_vld0),
        .busy          (busy0)
    );

    uart_hex_tx #(
        .NIBBLES   (4),
        .UPPERCASE (0)
    ) dut1 (
        .clk           (clk),
        .rst           (rst1),
        .in_data       (in_data1),
        .in_valid      (in_valid1),
        .in_ready      (in_ready1),
        .tx_free       (1'b1),
        .tx_data       (tx_data1),
        .tx_data_valid (tx_vld1),
        .busy          (busy1)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------ monitors
    logic [7:0] q0[$];
    int         c0[$];
    logic [7:0] q1[$];
    logic [7:0] last0 = 8'h00;
    int         hold_err = 0;

    always @(negedge clk) begin
        if (rst0) begin
            last0 = 8'h00;
        end else if (tx_vld0) begin
            q0.push_back(tx_data0);
            c0.push_back(cyc);
            last0 = tx_data0;
        end else if (tx_data0 !== last0) begin
            hold_err++;
        end
        if (!rst1 && tx_vld1) q1.push_back(tx_data1);
    end

    // ------------------------------------------------------------ helpers
    logic [7:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_add(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`ifdef UART_HEX_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic compare_stream(input string tag, input logic [7:0] got[$]);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
        end
    endtask

    task automatic send0(input logic [31:0] w, output int acc);
        int n = 0;
        while (!in_ready0 && n < 200) begin tick(); n++; end
        if (n >= 200) check("send0_ready_timeout", 0, 1);
        in_valid0 = 1'b1;
        in_data0  = w;
        acc       = cyc;
        tick();
        in_valid0 = 1'b0;
        in_data0  = 32'h5A5A_5A5A;  // must not leak into the word in flight
    endtask

    task automatic wait_idle0(input string tag);
        int n = 0;
        while (busy0 && n < 400) begin tick(); n++; end
        if (n >= 400) check({tag, "_idle_timeout"}, 0, 1);
    endtask

    task automatic wait_strobes0(input int cnt, input string tag);
        int n = 0;
        while (q0.size() < cnt && n < 200) begin tick(); n++; end
        if (n >= 200) check({tag, "_strobe_timeout"}, q0.size(), cnt);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int acc;
        int n_stall;
        int acc2;
        int sz_at;
        int n;

        repeat (3) tick();
        rst0 = 1'b0;
        rst1 = 1'b0;
        check("rst_in_ready", in_ready0, 1'b1);
        check("rst_busy", busy0, 1'b0);
        check("rst_tx_vld", tx_vld0, 1'b0);
        check("rst_tx_data", tx_data0, 8'h00);

        // Full word at full rate: digits, spacing and first-strobe latency.
        q0.delete(); c0.delete(); exp_q.delete();
        exp_add("DEADBEEF");
        send0(32'hDEAD_BEEF, acc);
        wait_idle0("deadbeef");
        compare_stream("deadbeef", q0);
        if (c0.size() > 0) check("deadbeef_latency", c0[0] - acc, 1);
        for (int i = 1; i < c0.size(); i++) begin
            check($sformatf("deadbeef_spacing%0d", i), c0[i] - c0[i-1], 3);
        end
        tick();
        check("deadbeef_busy_after", busy0, 1'b0);
        check("deadbeef_ready_after", in_ready0, 1'b1);

        // Transmitter stall after the 3rd strobe.
        q0.delete(); c0.delete(); exp_q.delete();
        exp_add("12345678");
        send0(32'h1234_5678, acc);
        wait_strobes0(3, "stall");
        tx_free0 = 1'b0;
        n_stall  = q0.size();
        repeat (50) tick();
        check("stall_no_strobe", q0.size(), n_stall);
        check("stall_busy", busy0, 1'b1);
        tx_free0 = 1'b1;
        wait_idle0("stall");
        compare_stream("stall", q0);
        if (q0.size() > 3) check("stall_resume_char", q0[3], 8'h34);

        // Reset in the middle of a word.
        q0.delete(); c0.delete(); exp_q.delete();
        send0(32'hAAAA_AAAA, acc);
        wait_strobes0(2, "midrst");
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        check("midrst_in_ready", in_ready0, 1'b1);
        check("midrst_busy", busy0, 1'b0);
        repeat (30) tick();
        check("midrst_no_more", q0.size(), 2);
        check("midrst_tx_data", tx_data0, 8'h00);
        q0.delete(); c0.delete(); exp_q.delete();
        exp_add("00000001");
        send0(32'h0000_0001, acc);
        wait_idle0("after_rst");
        compare_stream("after_rst", q0);

        // Back-to-back words with in_valid held high.
        q0.delete(); c0.delete(); exp_q.delete();
        exp_add("0000000F");
        exp_add("000000F0");
        in_valid0 = 1'b1;
        in_data0  = 32'h0000_000F;
        n = 0;
        while (!in_ready0 && n < 50) begin tick(); n++; end
        acc = cyc;
        tick();
        in_data0 = 32'h0000_00F0;
        n = 0;
        sz_at = -1;
        acc2 = acc;
        while (n < 400) begin
            if (in_ready0) begin
                sz_at = q0.size();
                acc2  = cyc;
                tick();
                break;
            end
            tick();
            n++;
        end
        in_valid0 = 1'b0;
        check("b2b_second_accepted", (sz_at >= 0), 1'b1);
        check("b2b_first_word_done", sz_at, exp_q.size() / 2);
        // Strobes at acc+1, +3 each; two gap cycles after the last, then idle.
        check("b2b_word_cycles", acc2 - acc, 3 * (exp_q.size() / 2) + 1);
        wait_idle0("b2b");
        compare_stream("b2b", q0);

        check("tx_data_hold", hold_err, 0);

        // Lowercase, 4-digit instance.
        exp_q.delete();
        exp_add("ffee");
        in_valid1 = 1'b1;
        in_data1  = 32'h00C0_FFEE;
        tick();
        in_valid1 = 1'b0;
        in_data1  = 32'hFFFF_FFFF;
        n = 0;
        while (busy1 && n < 200) begin tick(); n++; end
        if (n >= 200) check("ffee_idle_timeout", 0, 1);
        compare_stream("ffee", q1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_uart_hex_tx
